// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port 1-cycle-latency memory between instruction fetch and load/store,
// data-priority with a streak limit so fetch cannot starve, plus a saturating fetch-stall counter.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_STREAK = 3,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  fetch_stall_cnt
);
    localparam logic [1:0] OWN_NONE  = 2'd0;
    localparam logic [1:0] OWN_FETCH = 2'd1;
    localparam logic [1:0] OWN_DATA  = 2'd2;
    localparam logic [3:0] MAX_S     = 4'(MAX_STREAK);

    logic [3:0] streak;
    logic [1:0] owner;
    logic       we_q;
    logic       data_win;

    always_comb begin
        data_win  = d_req && (!if_req || streak < MAX_S);
        d_gnt     = reset && data_win;
        if_gnt    = reset && if_req && !data_win;
        mem_en    = d_gnt || if_gnt;
        mem_we    = d_gnt && d_we;
        mem_addr  = d_gnt ? d_addr : if_gnt ? if_addr : '0;
        mem_wdata = d_gnt ? d_wdata : '0;
        if_valid  = owner == OWN_FETCH;
        d_valid   = owner == OWN_DATA;
        if_rdata  = if_valid ? mem_rdata : '0;
        d_rdata   = (d_valid && !we_q) ? mem_rdata : '0;
    end

    // the streak only counts data wins that actually held a fetch off
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner           <= OWN_NONE;
            we_q            <= 1'b0;
            streak          <= '0;
            fetch_stall_cnt <= '0;
        end else begin
            owner  <= d_gnt ? OWN_DATA : if_gnt ? OWN_FETCH : OWN_NONE;
            we_q   <= d_gnt && d_we;
            streak <= (d_gnt && if_req) ? ((streak == MAX_S) ? streak : streak + 4'd1) : '0;
            if (if_req && !if_gnt && fetch_stall_cnt != '1)
                fetch_stall_cnt <= fetch_stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed test-plan scenarios plus randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;
    localparam int MS = 3;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt, if_valid;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0, d_we = 1'b0;
    logic [31:0] d_addr = '0, d_wdata = '0;
    logic        d_gnt, d_valid;
    logic [31:0] d_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [15:0] fetch_stall_cnt;

    logic        s_if_req = 1'b0, s_d_req = 1'b0;
    logic        s_if_gnt, s_if_valid, s_d_gnt, s_d_valid, s_mem_en, s_mem_we;
    logic [31:0] s_if_rdata, s_d_rdata, s_mem_addr, s_mem_wdata;
    logic [3:0]  s_cnt;

    logic        pl_en = 1'b0;
    logic [7:0]  pl_a = '0;
    logic [31:0] pl_d = '0;
    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];

    int          n_tot = 0, n_bad = 0;
    int          m_streak = 0, m_stall = 0, m_pend = 0;
    logic [31:0] m_pdata = '0;
    logic        o_if_gnt, o_d_gnt, o_if_valid, o_d_valid;
    logic [31:0] o_if_rdata, o_d_rdata;
    logic [15:0] o_cnt;
    logic [3:0]  o_streak;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .fetch_stall_cnt(fetch_stall_cnt)
    );

    mem_port_arbiter #(.MAX_STREAK(15), .CNT_W(4)) dut2 (
        .clk(clk), .reset(reset),
        .if_req(s_if_req), .if_addr(32'h0), .if_gnt(s_if_gnt), .if_valid(s_if_valid), .if_rdata(s_if_rdata),
        .d_req(s_d_req), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
        .d_gnt(s_d_gnt), .d_valid(s_d_valid), .d_rdata(s_d_rdata),
        .mem_en(s_mem_en), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
        .mem_rdata(32'h0), .fetch_stall_cnt(s_cnt)
    );

    // memory with a bench-side preload port
    always @(posedge clk) begin
        if (pl_en)
            mem[pl_a] <= pl_d;
        else if (mem_en && mem_we)
            mem[mem_addr[9:2]] <= mem_wdata;
        else if (mem_en)
            mem_rdata <= mem[mem_addr[9:2]];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [31:0] d);
        pl_en = 1'b1; pl_a = a; pl_d = d;
        ref_mem[a] = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // one cycle: drive, compare everything against the model, then advance the model
    task automatic step(input logic ir, input logic [31:0] ia, input logic dr, input logic dwe,
                        input logic [31:0] da, input logic [31:0] dwd);
        logic ed, ef;
        if_req = ir; if_addr = ia; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
        @(negedge clk);
        ed = dr && (!ir || m_streak < MS);
        ef = ir && !ed;
        check("if_gnt", if_gnt, ef);
        check("d_gnt", d_gnt, ed);
        check("mem_en", mem_en, ed || ef);
        check("mem_we", mem_we, ed && dwe);
        check("mem_addr", mem_addr, ed ? da : ef ? ia : 32'h0);
        check("mem_wdata", mem_wdata, ed ? dwd : 32'h0);
        check("if_valid", if_valid, m_pend == 1);
        check("if_rdata", if_rdata, (m_pend == 1) ? m_pdata : 32'h0);
        check("d_valid", d_valid, m_pend >= 2);
        check("d_rdata", d_rdata, (m_pend == 2) ? m_pdata : 32'h0);
        check("stall_cnt", fetch_stall_cnt, m_stall);
        check("streak", dut.streak, m_streak);
        o_if_gnt = if_gnt; o_d_gnt = d_gnt; o_if_valid = if_valid; o_d_valid = d_valid;
        o_if_rdata = if_rdata; o_d_rdata = d_rdata; o_cnt = fetch_stall_cnt; o_streak = dut.streak;
        if (ir && !ef && m_stall < 65535) m_stall++;
        m_streak = (ed && ir) ? ((m_streak < MS) ? m_streak + 1 : MS) : 0;
        if (ef) begin
            m_pend = 1; m_pdata = ref_mem[ia[9:2]];
        end else if (ed && dwe) begin
            m_pend = 3; ref_mem[da[9:2]] = dwd;
        end else if (ed) begin
            m_pend = 2; m_pdata = ref_mem[da[9:2]];
        end else
            m_pend = 0;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic        ir, dr, dwe;
        logic [31:0] ia, da, dwd;
        logic [7:0]  pat;
        if_req = 1'b1; d_req = 1'b1;
        for (int i = 0; i < 256; i++) poke(8'(i), $urandom);
        poke(8'd0, 32'h20080005);
        poke(8'd1, 32'h20090007);
        poke(8'd2, 32'h01095020);
        poke(8'h80, 32'h11112222);
        poke(8'h81, 32'hCAFEF00D);
        @(negedge clk);
        check("rst_if_gnt", if_gnt, 1'b0);
        check("rst_d_gnt", d_gnt, 1'b0);
        check("rst_mem_en", mem_en, 1'b0);
        check("rst_if_valid", if_valid, 1'b0);
        check("rst_d_valid", d_valid, 1'b0);
        check("rst_cnt", fetch_stall_cnt, 16'h0);
        @(posedge clk); #1;
        if_req = 1'b0; d_req = 1'b0; reset = 1'b1;

        step(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0);
        check("tp_fetch_w0", o_if_rdata, 32'h20080005);
        step(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0);
        check("tp_fetch_w1", o_if_rdata, 32'h20090007);
        idle();
        check("tp_fetch_w2", o_if_rdata, 32'h01095020);
        check("tp_fetch_cnt", o_cnt, 16'h0);

        step(1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF);
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0);
        check("tp_store_valid", o_d_valid, 1'b1);
        check("tp_store_rdata", o_d_rdata, 32'h0);
        idle();
        check("tp_load_valid", o_d_valid, 1'b1);
        check("tp_load_rdata", o_d_rdata, 32'hDEADBEEF);

        pat = 8'b0111_0111;
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 32'h14, 1'b1, 1'b0, 32'h10, 32'h0);
            check("tp_starve_pat", o_d_gnt, pat[k]);
            if (k == 4) check("tp_starve_cnt", o_cnt, 16'd3);
        end

        step(1'b1, 32'h204, 1'b1, 1'b0, 32'h200, 32'h0);
        check("tp_burst_g0", o_d_gnt, 1'b1);
        step(1'b1, 32'h204, 1'b1, 1'b0, 32'h208, 32'h0);
        check("tp_burst_g1", o_d_gnt, 1'b1);
        check("tp_burst_dload", o_d_rdata, 32'h11112222);
        step(1'b1, 32'h204, 1'b0, 1'b0, 32'h0, 32'h0);
        check("tp_burst_g2", o_if_gnt, 1'b1);
        idle();
        check("tp_burst_streak", o_streak, 4'd0);
        check("tp_burst_ifdata", o_if_rdata, 32'hCAFEF00D);

        step(1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("tp_rst_if_valid", if_valid, 1'b0);
            check("tp_rst_if_gnt", if_gnt, 1'b0);
            check("tp_rst_cnt", fetch_stall_cnt, 16'h0);
            check("tp_rst_streak", dut.streak, 4'd0);
            @(posedge clk); #1;
        end
        if_req = 1'b0;
        reset = 1'b1;
        m_pend = 0; m_streak = 0; m_stall = 0;
        idle();
        check("tp_rst_novalid", o_if_valid, 1'b0);
        step(1'b1, 32'h24, 1'b0, 1'b0, 32'h0, 32'h0);
        check("tp_rst_regrant", o_if_gnt, 1'b1);
        idle();
        check("tp_rst_revalid", o_if_valid, 1'b1);

        ir = 1'b0; dr = 1'b0; dwe = 1'b0; ia = '0; da = '0; dwd = '0;
        for (int n = 0; n < 1500; n++) begin
            if (!ir || o_if_gnt) begin
                ir = $urandom_range(0, 3) != 0;
                ia = 32'($urandom_range(0, 255)) << 2;
            end else if ($urandom_range(0, 15) == 0)
                ir = 1'b0;
            if (!dr || o_d_gnt) begin
                dr = $urandom_range(0, 2) != 0;
                dwe = $urandom_range(0, 1) != 0;
                da = 32'($urandom_range(0, 255)) << 2;
                dwd = $urandom;
            end else if ($urandom_range(0, 15) == 0)
                dr = 1'b0;
            step(ir, ia, dr, dwe, da, dwd);
        end
        idle();

        s_if_req = 1'b1; s_d_req = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 15) check("tp_sat_dgnt", s_d_gnt, 1'b1);
        end
        check("tp_sat_cnt15", s_cnt, 4'd15);
        check("tp_sat_fgnt", s_if_gnt, 1'b1);
        for (int k = 0; k < 40; k++) @(negedge clk);
        check("tp_sat_hold", s_cnt, 4'd15);
        s_if_req = 1'b0; s_d_req = 1'b0;

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous memory between the CPU instruction-fetch path and the load/store data path.
- The memory has a 1-cycle read latency.
- Arbitration gives data accesses priority. A streak limit prevents fetch starvation.
- The block tracks the single in-flight response, routes memory read data back to the requester that was granted, and keeps a saturating fetch-stall counter for the testbench to inspect.
- It sits between the CPU core (pc/instruction fetch and the load/store unit) and the unified memory.

Parameters:
- ADDR_W, 32, address width in bits; byte addresses pass through unchanged.
- DATA_W, 32, data width in bits.
- MAX_STREAK, 3, maximum consecutive data grants allowed while a fetch is pending (range 1..15).
- CNT_W, 16, width of the fetch-stall counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- if_req  in  1  fetch request.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  fetch granted this cycle (combinational).
- if_valid  out  1  fetch data valid (cycle after grant).
- if_rdata  out  DATA_W  fetched instruction.
- d_req  in  1  data request.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data granted this cycle (combinational).
- d_valid  out  1  load data / store ack valid (cycle after grant).
- d_rdata  out  DATA_W  load data.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid the cycle after mem_en with mem_we=0.
- fetch_stall_cnt  out  CNT_W  number of cycles with if_req=1 and if_gnt=0, saturating.

Behaviour:
- Reset (reset=0, asynchronous):
  - if_valid=0, d_valid=0.
  - Response-owner register = NONE.
  - streak=0, fetch_stall_cnt=0.
  - if_gnt, d_gnt and mem_en are forced to 0 while reset=0.
- Reset mid-operation: any in-flight response is discarded. No valid pulse appears after reset release.
- Arbitration is evaluated every cycle and is combinational from the req inputs and streak:
  - Only d_req: data granted.
  - Only if_req: fetch granted.
  - Both: data granted if streak < MAX_STREAK, otherwise fetch granted.
  - Neither: no grant, mem_en=0.
- At most one grant per cycle; if_gnt and d_gnt are never both 1.
- Memory-side outputs during a grant:
  - mem_en=1.
  - mem_addr = the granted requester's address.
  - mem_we = d_we on a data grant, 0 on a fetch grant.
  - mem_wdata = d_wdata on a data grant.
- Memory-side outputs with no grant: mem_addr, mem_wdata and mem_we are 0.
- streak update:
  - Data granted while if_req=1: streak increments, saturating at MAX_STREAK.
  - Fetch granted, or if_req=0: streak resets to 0.
- Response-owner register: loaded at clk edge with FETCH, DATA or NONE according to the grant in that cycle.
- Response cycle (cycle N+1 after a grant in cycle N):
  - Owner=FETCH: if_valid=1, if_rdata=mem_rdata.
  - Owner=DATA: d_valid=1. d_rdata=mem_rdata for a load, 0 for a store.
  - The store/load distinction is taken from a registered copy of d_we.
  - The rdata output of the non-owning requester is 0.
- Valid pulses last exactly 1 cycle per grant.
- Back-to-back grants are legal. Throughput is 1 access per cycle, and the response for grant N overlaps arbitration for N+1.
- Requesters hold req/addr/wdata stable until they see gnt. Dropping req before gnt is legal and costs nothing.
- fetch_stall_cnt increments at the clk edge in any cycle where if_req=1 and if_gnt=0. It saturates at 2^CNT_W-1 and never wraps.
- No internal queue; the memory latency is fixed at 1 cycle. A write and a read of the same address in consecutive cycles return the newly written data; the memory guarantees this.

Test Plan:
- Reset, then if_req=1 with if_addr=0x0, 0x4, 0x8 on consecutive cycles and memory preloaded with 0x20080005, 0x20090007, 0x01095020:
  - if_gnt=1 each cycle.
  - if_valid on the following cycles with those words in order.
  - fetch_stall_cnt=0.
- Single store then load: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, then d_we=0 at the same address:
  - First response: d_valid=1 with d_rdata=0.
  - Second response: d_valid=1 with d_rdata=0xDEADBEEF.
- Starvation guard: if_req and d_req held at 1 continuously, MAX_STREAK=3:
  - Grant pattern D,D,D,F repeating.
  - fetch_stall_cnt=3 after the first fetch grant.
- Contention with short data burst: d_req high for 2 cycles while if_req is held:
  - Grants are D,D,F.
  - streak returns to 0 on the F grant.
  - if_rdata returns the fetch word, not the data word.
- Reset asserted (reset=0) the cycle after a fetch grant:
  - if_valid stays 0 throughout.
  - All counters read 0 after release.
  - The first post-reset grant behaves normally.
- Saturation with CNT_W=4: d_req held, if_req held, MAX_STREAK=15:
  - fetch_stall_cnt reaches 15.
  - It stays at 15 and does not wrap.
